// File: rtl/tmds_dec.sv
// TMDS channel decoder: control-token/data decode with registered outputs and a
// word-alignment FSM that hunts for control tokens and requests bitslips.
module tmds_dec #(
    parameter int WINDOW    = 2048,
    parameter int LOCK_RUN  = 8,
    parameter int SLIP_WAIT = 4
) (
    input  logic       pi_clk,
    input  logic       pi_rst,
    input  logic [9:0] pi_data,
    output logic [7:0] po_data,
    output logic       po_de,
    output logic [1:0] po_control,
    output logic       po_locked,
    output logic       po_bitslip
);

    localparam int WW        = $clog2(WINDOW + 1);
    localparam int RW        = (LOCK_RUN > 1) ? $clog2(LOCK_RUN + 1) : 1;
    localparam int SW        = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT + 1) : 1;
    localparam int SLIP_LAST = (SLIP_WAIT > 1) ? SLIP_WAIT - 1 : 0;

    localparam logic [WW-1:0] WIN_MAX  = WW'(WINDOW);
    localparam logic [RW-1:0] RUN_MAX  = RW'(LOCK_RUN);
    localparam logic [SW-1:0] SLP_LAST = SW'(SLIP_LAST);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        SLIP   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [WW-1:0] win, win_n, win_inc;
    logic [RW-1:0] run, run_n, run_inc;
    logic [SW-1:0] slp, slp_n;
    logic          bs_n;

    logic          is_tok;
    logic [1:0]    tok_val;
    logic [7:0]    d_unmasked;
    logic [7:0]    d_xor;
    logic [7:0]    dec;

    logic [7:0]    data_n;
    logic          de_n;
    logic [1:0]    ctrl_n;
    logic          locked_n;

    always_comb begin
        is_tok  = 1'b1;
        tok_val = 2'b00;
        case (pi_data)
            10'b1101010100: tok_val = 2'b00;
            10'b0010101011: tok_val = 2'b01;
            10'b0101010100: tok_val = 2'b10;
            10'b1010101011: tok_val = 2'b11;
            default:        is_tok  = 1'b0;
        endcase
    end

    // Bit 0 passes straight through; higher bits undo the XOR/XNOR chain.
    always_comb begin
        d_unmasked = pi_data[7:0] ^ {8{pi_data[9]}};
        d_xor      = d_unmasked ^ {d_unmasked[6:0], 1'b0};
        dec        = pi_data[8] ? d_xor : {~d_xor[7:1], d_xor[0]};
    end

    always_comb begin
        win_inc = (win == WIN_MAX) ? win : win + WW'(1);
        run_inc = (run == RUN_MAX) ? run : run + RW'(1);
    end

    always_ff @(posedge pi_clk or negedge pi_rst) begin
        if (!pi_rst) begin
            state <= SEARCH;
            win   <= '0;
            run   <= '0;
            slp   <= '0;
        end else begin
            state <= state_n;
            win   <= win_n;
            run   <= run_n;
            slp   <= slp_n;
        end
    end

    always_comb begin
        state_n = state;
        win_n   = win;
        run_n   = run;
        slp_n   = slp;
        bs_n    = 1'b0;
        case (state)
            SEARCH: begin
                if (is_tok) begin
                    win_n   = '0;
                    run_n   = RW'(1);
                    state_n = (LOCK_RUN <= 1) ? LOCKED : VERIFY;
                end else begin
                    win_n = win_inc;
                    if (win_inc == WIN_MAX) begin
                        state_n = SLIP;
                        bs_n    = 1'b1;
                        win_n   = '0;
                        slp_n   = '0;
                    end
                end
            end
            SLIP: begin
                if (slp == SLP_LAST) begin
                    state_n = SEARCH;
                    win_n   = '0;
                    slp_n   = '0;
                end else begin
                    slp_n = slp + SW'(1);
                end
            end
            VERIFY: begin
                if (is_tok) begin
                    run_n = run_inc;
                    if (run_inc == RUN_MAX) state_n = LOCKED;
                end else begin
                    state_n = SEARCH;
                    run_n   = '0;
                    win_n   = '0;
                end
            end
            LOCKED: begin
                // A token on the same word the window expires still wins.
                if (is_tok) begin
                    win_n = '0;
                end else begin
                    win_n = win_inc;
                    if (win_inc == WIN_MAX) begin
                        state_n = SEARCH;
                        win_n   = '0;
                        run_n   = '0;
                    end
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    // Outputs follow the lock status the word leaves behind, so po_de can never
    // be high on a cycle where po_locked is low.
    always_comb begin
        locked_n = (state_n == LOCKED);
        data_n   = 8'h00;
        de_n     = 1'b0;
        ctrl_n   = 2'b00;
        if (locked_n) begin
            if (is_tok) begin
                ctrl_n = tok_val;
            end else begin
                de_n   = 1'b1;
                data_n = dec;
                ctrl_n = po_control;
            end
        end
    end

    always_ff @(posedge pi_clk or negedge pi_rst) begin
        if (!pi_rst) begin
            po_data    <= 8'h00;
            po_de      <= 1'b0;
            po_control <= 2'b00;
            po_locked  <= 1'b0;
            po_bitslip <= 1'b0;
        end else begin
            po_data    <= data_n;
            po_de      <= de_n;
            po_control <= ctrl_n;
            po_locked  <= locked_n;
            po_bitslip <= bs_n;
        end
    end

endmodule

// File: tb/tb_tmds_dec.sv
// Randomized bench for tmds_dec: a word-level reference model feeds an expected
// queue that is checked every cycle, plus directed lock/slip/reset scenarios.
module tb_tmds_dec;

    localparam int WINDOW    = 16;
    localparam int LOCK_RUN  = 8;
    localparam int SLIP_WAIT = 4;

    localparam int MS_SEARCH = 0;
    localparam int MS_VERIFY = 1;
    localparam int MS_SLIP   = 2;
    localparam int MS_LOCKED = 3;

    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;
    localparam logic [9:0] TOK10 = 10'b0101010100;
    localparam logic [9:0] TOK11 = 10'b1010101011;

    logic       pi_clk;
    logic       pi_rst;
    logic [9:0] pi_data;
    logic [7:0] po_data;
    logic       po_de;
    logic [1:0] po_control;
    logic       po_locked;
    logic       po_bitslip;

    int n_checks = 0;
    int n_fail   = 0;

    logic [12:0] exp_q[$];

    int         m_st   = MS_SEARCH;
    int         m_win  = 0;
    int         m_run  = 0;
    int         m_slp  = 0;
    logic [1:0] m_ctrl = 2'b00;

    tmds_dec #(
        .WINDOW   (WINDOW),
        .LOCK_RUN (LOCK_RUN),
        .SLIP_WAIT(SLIP_WAIT)
    ) dut (
        .pi_clk    (pi_clk),
        .pi_rst    (pi_rst),
        .pi_data   (pi_data),
        .po_data   (po_data),
        .po_de     (po_de),
        .po_control(po_control),
        .po_locked (po_locked),
        .po_bitslip(po_bitslip)
    );

    // clock / reset
    initial pi_clk = 1'b0;
    always #5 pi_clk = ~pi_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // reference model
    function automatic int tok_ref(input logic [9:0] w);
        if (w == TOK00) return 0;
        if (w == TOK01) return 1;
        if (w == TOK10) return 2;
        if (w == TOK11) return 3;
        return -1;
    endfunction

    function automatic logic [7:0] dec_ref(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] o;
        for (int i = 0; i < 8; i++) d[i] = w[i] ^ w[9];
        o[0] = d[0];
        for (int i = 1; i < 8; i++) o[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return o;
    endfunction

    task automatic model_step(input logic [9:0] w);
        int         t;
        logic       obs;
        logic       oe;
        logic [7:0] od;
        logic [1:0] oc;
        t   = tok_ref(w);
        obs = 1'b0;
        if (!pi_rst) begin
            m_st = MS_SEARCH; m_win = 0; m_run = 0; m_slp = 0; m_ctrl = 2'b00;
            exp_q.push_back(13'h0);
            return;
        end
        case (m_st)
            MS_SEARCH:
                if (t >= 0) begin
                    m_win = 0; m_run = 1;
                    m_st  = (m_run >= LOCK_RUN) ? MS_LOCKED : MS_VERIFY;
                end else begin
                    m_win++;
                    if (m_win >= WINDOW) begin
                        m_win = 0; m_slp = 0; obs = 1'b1; m_st = MS_SLIP;
                    end
                end
            MS_SLIP: begin
                m_slp++;
                if (m_slp >= SLIP_WAIT) begin
                    m_st = MS_SEARCH; m_win = 0;
                end
            end
            MS_VERIFY:
                if (t >= 0) begin
                    m_run++;
                    if (m_run >= LOCK_RUN) m_st = MS_LOCKED;
                end else begin
                    m_st = MS_SEARCH; m_run = 0; m_win = 0;
                end
            default:
                if (t >= 0) begin
                    m_win = 0;
                end else begin
                    m_win++;
                    if (m_win >= WINDOW) begin
                        m_st = MS_SEARCH; m_win = 0; m_run = 0;
                    end
                end
        endcase
        if (m_st == MS_LOCKED) begin
            if (t >= 0) begin
                od = 8'h00; oe = 1'b0; m_ctrl = 2'(t);
            end else begin
                od = dec_ref(w); oe = 1'b1;
            end
            oc = m_ctrl;
        end else begin
            od = 8'h00; oe = 1'b0; oc = 2'b00; m_ctrl = 2'b00;
        end
        exp_q.push_back({(m_st == MS_LOCKED) ? 1'b1 : 1'b0, obs, oe, oc, od});
    endtask

    // driver tasks
    task automatic drive(input logic [9:0] w);
        pi_data = w;
        model_step(w);
        @(negedge pi_clk);
    endtask

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom_range(0, 1023)); while (tok_ref(w) >= 0);
        return w;
    endfunction

    function automatic logic [9:0] rand_tok();
        case ($urandom_range(0, 3))
            0:       return TOK00;
            1:       return TOK01;
            2:       return TOK10;
            default: return TOK11;
        endcase
    endfunction

    task automatic relock();
        for (int i = 0; i < 40 && m_st != MS_LOCKED; i++) drive(TOK00);
        chk("relock_locked", 32'(po_locked), 32'd1);
    endtask

    // scoreboard: one comparison per cycle that has an expected entry
    logic prev_bs = 1'b0;
    always @(posedge pi_clk) begin
        logic [12:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle_outputs", 32'({po_locked, po_bitslip, po_de, po_control, po_data}), 32'(e));
            chk("bitslip_gap", 32'(prev_bs & po_bitslip), 32'd0);
        end
        prev_bs = po_bitslip;
    end

    // stimulus
    initial begin
        int quiet;
        int seen;
        pi_rst  = 1'b0;
        pi_data = 10'h000;

        chk("pin_dec_100", 32'(dec_ref(10'h100)), 32'h00);
        chk("pin_dec_200", 32'(dec_ref(10'h200)), 32'hFF);
        chk("pin_dec_1ff", 32'(dec_ref(10'h1FF)), 32'h01);
        chk("pin_tok_11",  32'(tok_ref(TOK11)), 32'd3);

        repeat (3) @(negedge pi_clk);
        chk("reset_outputs", 32'({po_locked, po_bitslip, po_de, po_control, po_data}), 32'd0);
        pi_rst = 1'b1;

        // eight 00 tokens: lock appears right after the eighth
        for (int i = 0; i < LOCK_RUN; i++) begin
            drive(TOK00);
            if (i == LOCK_RUN - 2) chk("lock_not_yet", 32'(po_locked), 32'd0);
            chk("lock_seq_de", 32'({po_de, po_control}), 32'd0);
        end
        chk("lock_after_8", 32'(po_locked), 32'd1);

        drive(10'h100);
        chk("dec_100", 32'({po_data, po_de}), 32'h001);
        drive(10'h200);
        chk("dec_200", 32'({po_data, po_de}), 32'h1FF);
        drive(TOK11);
        chk("tok_11", 32'({po_data, po_de, po_control}), 32'h003);

        for (int i = 0; i < 200; i++) drive(($urandom_range(0, 7) == 0) ? rand_tok() : rand_data());

        // window boundary while locked
        relock();
        for (int i = 0; i < WINDOW - 1; i++) drive(rand_data());
        drive(TOK01);
        chk("token_on_window_keeps_lock", 32'(po_locked), 32'd1);
        for (int i = 0; i < WINDOW - 1; i++) drive(rand_data());
        chk("lock_before_window", 32'(po_locked), 32'd1);
        drive(rand_data());
        chk("lock_lost", 32'({po_locked, po_de, po_bitslip}), 32'd0);

        // search: one slip pulse per window, spaced by SLIP_WAIT+WINDOW
        seen = 0;
        for (int i = 0; i < WINDOW; i++) begin
            drive(rand_data());
            seen += int'(po_bitslip);
        end
        chk("slip_pulse_count", 32'(seen), 32'd1);
        chk("slip_pulse_last", 32'(po_bitslip), 32'd1);
        quiet = 0;
        for (int i = 0; i < SLIP_WAIT + WINDOW - 1; i++) begin
            drive(rand_data());
            quiet += int'(po_bitslip);
        end
        chk("slip_quiet", 32'(quiet), 32'd0);
        drive(rand_data());
        chk("slip_second", 32'(po_bitslip), 32'd1);

        // abort in VERIFY after five tokens
        for (int i = 0; i < SLIP_WAIT; i++) drive(TOK00);
        for (int i = 0; i < 5; i++) drive(TOK10);
        drive(rand_data());
        chk("verify_abort", 32'({po_locked, po_bitslip}), 32'd0);

        // asynchronous reset while locked
        relock();
        #2;
        pi_rst = 1'b0;
        exp_q.delete();
        #1;
        chk("async_reset", 32'({po_locked, po_bitslip, po_de, po_control, po_data}), 32'd0);
        @(negedge pi_clk);
        drive(TOK00);
        drive(TOK00);
        pi_rst = 1'b1;
        for (int i = 0; i < LOCK_RUN - 1; i++) drive(TOK00);
        chk("relock_needs_full_run", 32'(po_locked), 32'd0);
        drive(TOK00);
        chk("relock_after_reset", 32'(po_locked), 32'd1);

        for (int i = 0; i < 800; i++) drive(($urandom_range(0, 3) == 0) ? rand_tok() : rand_data());

        @(posedge pi_clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tmds_dec.md
TMDS_DEC -- requirements
Module: tmds_dec

Interface
REQ-001 Parameter WINDOW, default 2048: words (clock cycles) without any control token before an alignment slip (SEARCH) or loss of lock (LOCKED).
REQ-002 Parameter LOCK_RUN, default 8: consecutive control tokens required to declare lock.
REQ-003 Parameter SLIP_WAIT, default 4: idle cycles after a bitslip pulse before the search resumes.
REQ-004 pi_clk  input  1  symbol clock (pixel clock); sole clock; all state updates on its rising edge.
REQ-005 pi_rst  input  1  reset, asynchronous, active-low.
REQ-006 pi_data  input  10  raw TMDS word from the deserializer, bit 0 first on the wire; one word per cycle.
REQ-007 po_data  output  8  decoded pixel byte.
REQ-008 po_de  output  1  display enable: 1 = po_data is a video word, 0 = blanking.
REQ-009 po_control  output  2  decoded control pair {C1,C2}.
REQ-010 po_locked  output  1  word alignment achieved.
REQ-011 po_bitslip  output  1  one-cycle pulse requesting the deserializer to shift word alignment by one bit.

Function
REQ-012 Control tokens (pi_data, MSB first) SHALL decode as follows: 1101010100->00, 0010101011->01, 0101010100->10, 1010101011->11; any other word is a data word.
REQ-013 Data decode: d = pi_data[7:0] XOR {8{pi_data[9]}}; out[0] = d[0]; for i=1..7, out[i] = d[i] XOR d[i-1] if pi_data[8]=1, else NOT(d[i] XOR d[i-1]).
REQ-014 Outputs SHALL be registered with latency exactly 1 cycle from the pi_data sample to po_data/po_de/po_control.
REQ-015 While locked, a data word SHALL produce po_de=1 and po_data=decoded value, and po_control SHALL hold its last value.
REQ-016 While locked, a control token SHALL produce po_de=0, po_data=0x00, and po_control=token value.
REQ-017 While not locked, the block SHALL force po_de=0, po_data=0x00 and po_control=00, regardless of pi_data.
REQ-018 FSM states SHALL be SEARCH, VERIFY, SLIP and LOCKED.
REQ-019 SEARCH: a control token moves to VERIFY with run counter=1; WINDOW consecutive non-token words assert po_bitslip for exactly 1 cycle and move to SLIP.
REQ-020 SLIP: wait SLIP_WAIT cycles, ignoring pi_data, then return to SEARCH with the window counter cleared.
REQ-021 VERIFY: each token increments the run counter; reaching LOCK_RUN moves to LOCKED with po_locked=1 on the next cycle.
REQ-022 VERIFY: a data word before reaching LOCK_RUN SHALL return to SEARCH with counters cleared and no slip.
REQ-023 LOCKED: any control token clears the window counter; WINDOW consecutive data words SHALL clear po_locked and go to SEARCH with no slip pulse.
REQ-024 Counters SHALL saturate and never wrap; the window counter width is ceil(log2(WINDOW+1)).
REQ-025 When a token arrives on the same cycle the window counter reaches WINDOW, the token wins (no slip, no lock loss).
REQ-026 po_bitslip SHALL never be asserted outside the SEARCH->SLIP transition, and never on two consecutive cycles.

Reset
REQ-027 While pi_rst=0: state=SEARCH, all counters=0, po_data=0x00, po_de=0, po_control=00, po_locked=0, po_bitslip=0.
REQ-028 Reset assertion mid-operation (including during SLIP or LOCKED) SHALL take effect immediately, asynchronously; a pending bitslip is dropped.
REQ-029 After reset release, operation SHALL resume from the first rising edge on which pi_rst=1.

Verification
REQ-030 Stream 8 consecutive 1101010100 words -> po_locked rises 1 cycle after the 8th token; po_de=0 and po_control=00 throughout.
REQ-031 Locked, then words 0x100, 0x200, 1010101011 -> po_data/po_de sequence 0x00/1, 0xFF/1, 0x00/0 with po_control=11, each 1 cycle after its input.
REQ-032 Unlocked, apply WINDOW (e.g. 16) random non-token words -> single po_bitslip pulse; no further pulse for SLIP_WAIT+WINDOW cycles.
REQ-033 In VERIFY after 5 tokens, insert one data word -> returns to SEARCH, po_locked stays 0, no bitslip.
REQ-034 Locked, apply WINDOW consecutive data words -> po_locked falls, po_de forced 0; a token on the WINDOW-th word instead -> lock retained.
REQ-035 Assert pi_rst low asynchronously mid-LOCKED -> all outputs zero immediately with no clock edge; re-lock requires LOCK_RUN fresh tokens.
